cakegame_seq_writer: RTL and testbench

Pattern-programming block for the cake game: records a sequence of player button presses into a 16-entry, 7-bit pattern memory that the game datapath later reads back. It is the writer of the memory the game reads. It turns raw button activity into one stored entry per press, tracks sequence length, and exposes a synchronous read port with the same 1-cycle latency as the game's pattern ROMs.

---
 rtl/cakegame_pkg.sv | 22 ++
 rtl/sync_ram_16x7.sv | 38 +++
 rtl/cakegame_seq_writer.sv | 125 ++++++++++++
 tb/tb_cakegame_seq_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cakegame_pkg.sv
// rtl/cakegame_pkg.sv - shared cake game constants, writer FSM states and pattern helpers
package cakegame_pkg;

    localparam int BTN_W           = 7;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 200000000;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_CAPTURE      = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_DONE         = 3'd4
    } wr_state_e;

    function automatic logic is_onehot(input logic [BTN_W-1:0] v);
        logic [BTN_W-1:0] one;
        one = {{(BTN_W-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

endpackage

// File: rtl/sync_ram_16x7.sv
// rtl/sync_ram_16x7.sv - DEPTH x 7 pattern memory, one write port, registered read-first read port
module sync_ram_16x7
    import cakegame_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [BTN_W-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [BTN_W-1:0] rd_data_o
);

    logic [BTN_W-1:0] mem_q [DEPTH];
    logic [BTN_W-1:0] rd_data_q;

    // Array is deliberately unreset so contents survive a game reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register resets; it samples the array before this edge's write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cakegame_seq_writer.sv
// rtl/cakegame_seq_writer.sv - records button presses into the pattern memory; CAKEGAME_SEQ_WRITER_ONEHOT_CHECK_EN rejects non-one-hot presses
module cakegame_seq_writer
    import cakegame_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             finish,
    input  logic [BTN_W-1:0] buttons,
    input  logic [AW-1:0]    rd_address,
    output logic [BTN_W-1:0] rd_data,
    output logic             recording,
    output logic             done,
    output logic [AW:0]      length,
    output logic             error
);

    wr_state_e        state_q, state_d;
    logic [AW:0]      length_q, length_d;
    logic             btn_q, btn_d;
    logic [BTN_W-1:0] cap_q, cap_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             press;
    logic             we;
    logic             reject;

    // A press is a rising edge of "any button"; held buttons never re-trigger.
    assign btn_d = |buttons;
    assign press = btn_d & ~btn_q;

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        cap_d    = cap_q;
        tmo_d    = tmo_q;
        we       = 1'b0;
        reject   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WAIT_PRESS;
                    length_d = '0;
                    tmo_d    = '0;
                end
            end
            ST_WAIT_PRESS: begin
                tmo_d = tmo_q + 1'b1;
                if (press) begin
                    cap_d   = buttons;
                    state_d = ST_CAPTURE;
                end else if (finish) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_CAPTURE: begin
`ifdef CAKEGAME_SEQ_WRITER_ONEHOT_CHECK_EN
                reject = ~is_onehot(cap_q);
`else
                reject = 1'b0;
`endif
                if (!reject) begin
                    we       = 1'b1;
                    length_d = length_q + 1'b1;
                end
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!btn_d) begin
                    if (length_q == (AW+1)'(DEPTH)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_PRESS;
                        tmo_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            length_q <= '0;
            btn_q    <= 1'b0;
            cap_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            btn_q    <= btn_d;
            cap_q    <= cap_d;
            tmo_q    <= tmo_d;
        end
    end

    sync_ram_16x7 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clock),
        .rst_n_i   (reset),
        .we_i      (we),
        .wr_addr_i (length_q[AW-1:0]),
        .wr_data_i (cap_q),
        .rd_addr_i (rd_address),
        .rd_data_o (rd_data)
    );

    assign recording = (state_q == ST_WAIT_PRESS) || (state_q == ST_CAPTURE) ||
                       (state_q == ST_WAIT_RELEASE);
    assign done      = (state_q == ST_DONE);
    assign length    = length_q;
    assign error     = reject;

endmodule

// File: tb/tb_cakegame_seq_writer.sv
// tb/tb_cakegame_seq_writer.sv - scoreboard bench for cakegame_seq_writer with TIMEOUT shortened to 20
module tb_cakegame_seq_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic [6:0]    buttons = '0;
    logic [AW-1:0] rd_address = '0;
    logic [6:0]    rd_data;
    logic          recording;
    logic          done;
    logic [AW:0]   length;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_mem [DEPTH];
    int         exp_len = 0;
    bit         exp_rec = 0;
    logic [6:0] sb_q [$];

    cakegame_seq_writer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TMO),
        .TW      (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .buttons    (buttons),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .recording  (recording),
        .done       (done),
        .length     (length),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic bit accepted(input logic [6:0] p);
`ifdef CAKEGAME_SEQ_WRITER_ONEHOT_CHECK_EN
        return $countones(p) == 1;
`else
        return p != 0;
`endif
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_len = 0;
        exp_rec = 1;
    endtask

    task automatic do_press(input logic [6:0] p, output logic err_cap);
        buttons = p;
        tick();
        err_cap = error;
        tick();
        buttons = '0;
        tick();
        if (exp_rec && accepted(p) && exp_len < DEPTH) begin
            exp_mem[exp_len] = p;
            exp_len++;
        end
        if (exp_len == DEPTH) exp_rec = 0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        exp_rec = 0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [6:0] d);
        rd_address = a;
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({recording, done, error} !== 3'b000 || length !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rec=%b done=%b err=%b len=%0d rd=%b, need all zero",
                     recording, done, error, length, rd_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic e;
        logic [6:0] d;
        do_start();
        total++;
        if (recording !== 1'b1) begin
            bad++;
            $display("FAIL basic_recording: got %b need 1", recording);
        end
        do_press(7'b0000001, e);
        total++;
        if (e !== 1'b0) begin
            bad++;
            $display("FAIL basic_error0: got %b need 0", e);
        end
        do_press(7'b0100000, e);
        do_finish();
        total++;
        if (done !== 1'b1 || recording !== 1'b0 || length !== 5'(exp_len)) begin
            bad++;
            $display("FAIL basic_done: done=%b rec=%b len=%0d need done=1 rec=0 len=%0d",
                     done, recording, length, exp_len);
        end
        for (int a = 0; a < 2; a++) begin
            sb_q.push_back(exp_mem[a]);
            read_word(AW'(a), d);
            total++;
            if (d !== sb_q[0]) begin
                bad++;
                $display("FAIL basic_read%0d: got %b need %b", a, d, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_hold();
        logic e;
        logic [6:0] d;
        do_start();
        buttons = 7'b0001000;
        for (int i = 0; i < 100; i++) tick();
        total++;
        if (length !== 5'd1) begin
            bad++;
            $display("FAIL hold_single: len=%0d need 1", length);
        end
        exp_mem[0] = 7'b0001000;
        exp_len = 1;
        buttons = '0;
        tick();
        do_press(7'b0000100, e);
        total++;
        if (length !== 5'(exp_len) || exp_len != 2) begin
            bad++;
            $display("FAIL hold_two: len=%0d need 2", length);
        end
        do_finish();
        for (int a = 0; a < 2; a++) begin
            sb_q.push_back(exp_mem[a]);
            read_word(AW'(a), d);
            total++;
            if (d !== sb_q[0]) begin
                bad++;
                $display("FAIL hold_read%0d: got %b need %b", a, d, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_onehot();
        logic e;
        logic exp_e;
        logic [6:0] d;
        do_start();
        exp_e = !accepted(7'b0000011);
        do_press(7'b0000011, e);
        total++;
        if (e !== exp_e) begin
            bad++;
            $display("FAIL onehot_error: got %b need %b", e, exp_e);
        end
        total++;
        if (error !== 1'b0 || length !== 5'(exp_len)) begin
            bad++;
            $display("FAIL onehot_after: err=%b len=%0d need err=0 len=%0d", error, length, exp_len);
        end
        do_finish();
        if (exp_len == 1) begin
            sb_q.push_back(exp_mem[0]);
            read_word('0, d);
            total++;
            if (d !== sb_q[0]) begin
                bad++;
                $display("FAIL onehot_read: got %b need %b", d, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_full();
        logic e;
        logic [6:0] d;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            do_press(7'(7'd1 << (i % 7)), e);
            if (i < DEPTH - 1) begin
                total++;
                if (done !== 1'b0 || length !== 5'(i + 1)) begin
                    bad++;
                    $display("FAIL full_step%0d: done=%b len=%0d need 0/%0d", i, done, length, i + 1);
                end
            end
        end
        total++;
        if (done !== 1'b1 || length !== 5'd16) begin
            bad++;
            $display("FAIL full_done: done=%b len=%0d need 1/16", done, length);
        end
        do_press(7'b1000000, e);
        total++;
        if (done !== 1'b1 || length !== 5'd16) begin
            bad++;
            $display("FAIL full_17th: done=%b len=%0d need 1/16", done, length);
        end
        for (int a = 0; a < DEPTH; a++) begin
            sb_q.push_back(exp_mem[a]);
            read_word(AW'(a), d);
            total++;
            if (d !== sb_q[0]) begin
                bad++;
                $display("FAIL full_read%0d: got %b need %b", a, d, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_timeout();
        int k;
        do_start();
        k = 0;
        while (done !== 1'b1 && k < 3 * TMO) begin
            tick();
            k++;
        end
        total++;
        if (k != TMO) begin
            bad++;
            $display("FAIL timeout_cycles: done after %0d cycles need %0d", k, TMO);
        end
        total++;
        if (length !== '0) begin
            bad++;
            $display("FAIL timeout_len: len=%0d need 0", length);
        end
        exp_rec = 0;
    endtask

    task automatic test_reset_mid();
        logic e;
        logic [6:0] d;
        do_start();
        do_press(7'b0010000, e);
        do_press(7'b0000010, e);
        buttons = 7'b1000000;
        tick();
        tick();
        exp_mem[2] = 7'b1000000;
        total++;
        if (length !== 5'd3 || recording !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: len=%0d rec=%b need 3/1", length, recording);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({recording, done, error} !== 3'b000 || length !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL mid_reset: rec=%b done=%b err=%b len=%0d rd=%b need zeros",
                     recording, done, error, length, rd_data);
        end
        exp_len = 0;
        exp_rec = 0;
        buttons = '0;
        tick();
        reset = 1'b1;
        tick();
        sb_q.push_back(exp_mem[2]);
        read_word(4'd2, d);
        total++;
        if (d !== sb_q[0]) begin
            bad++;
            $display("FAIL mid_read2: got %b need %b", d, sb_q[0]);
        end
        void'(sb_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_onehot();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
